accum_table_rd_seq: RTL and testbench

- Sequential read-address generator for the accumulator table. It replaces the per-cycle combinational address fan-out.
- On a single start it walks every row of one output submatrix (submat_m, submat_n). It issues per-column read enables and addresses.
- Two modes: aligned, where all columns read the same row, and skewed, where column c lags by c cycles to match the systolic-array diagonal.
- Sits between the top-level controller and the accumulator table read ports. Supports stall back-pressure and partial last tiles.

---
 rtl/accum_table_rd_seq.sv | 148 ++++++++++++++
 tb/tb_accum_table_rd_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_table_rd_seq.sv
// Accumulator table read sequencer.
// One start walks every row of one output submatrix. It issues per-column
// read enables and addresses, either aligned (all columns read the same row)
// or skewed (column c lags by c cycles to follow the systolic diagonal).
module accum_table_rd_seq #(
   parameter int MAX_OUT_ROWS = 128,
   parameter int MAX_OUT_COLS = 128,
   parameter int SYS_ARR_ROWS = 16,
   parameter int SYS_ARR_COLS = 16,
   parameter int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
   parameter int ADDR_W = $clog2(NUM_ACCUM_ROWS),
   parameter int M_W    = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS),
   parameter int N_W    = $clog2(MAX_OUT_COLS / SYS_ARR_COLS),
   parameter int NR_W   = $clog2(SYS_ARR_ROWS) + 1,
   parameter int T_W    = $clog2(SYS_ARR_ROWS + SYS_ARR_COLS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [M_W-1:0]               submat_m,
   input  logic [N_W-1:0]               submat_n,
   input  logic [NR_W-1:0]              num_rows,
   input  logic                         skew_mode,
   input  logic                         stall,
   output logic                         busy,
   output logic                         done,
   output logic [SYS_ARR_COLS-1:0]      rd_en,
   output logic [ADDR_W*SYS_ARR_COLS-1:0] rd_addr_out
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                          state_reg;
   logic [T_W-1:0]                  t_reg;
   logic [M_W-1:0]                  m_reg;
   logic [N_W-1:0]                  n_reg;
   logic [NR_W-1:0]                 rows_reg;
   logic                            skew_reg;
   logic                            busy_reg;
   logic                            done_reg;
   logic [SYS_ARR_COLS-1:0]         rd_en_reg;
   logic [ADDR_W*SYS_ARR_COLS-1:0]  rd_addr_reg;

   logic [NR_W-1:0]                 rows_in_eff;
   logic [ADDR_W-1:0]               base_addr;
   logic [T_W:0]                    last_t;
   logic                            last_slot;
   logic [SYS_ARR_COLS-1:0]         rd_en_next;
   logic [ADDR_W*SYS_ARR_COLS-1:0]  rd_addr_next;

   // Requested row count clipped to the submatrix height.
   assign rows_in_eff = (num_rows > NR_W'(SYS_ARR_ROWS)) ? NR_W'(SYS_ARR_ROWS) : num_rows;

   // Submatrix base: column-block stride is a full output-row span.
   assign base_addr = ADDR_W'(n_reg) * ADDR_W'(MAX_OUT_ROWS)
                    + ADDR_W'(m_reg) * ADDR_W'(SYS_ARR_ROWS);

   // Index of the final issue slot (T-1); skew adds one slot per extra column.
   assign last_t = skew_reg ? ((T_W+1)'(rows_reg) + (T_W+1)'(SYS_ARR_COLS - 1) - (T_W+1)'(1))
                            : ((T_W+1)'(rows_reg) - (T_W+1)'(1));
   assign last_slot = ({1'b0, t_reg} == last_t);

   // Per-column enable/address for the current slot t_reg.
   generate
      for (genvar gi = 0; gi < SYS_ARR_COLS; gi++) begin : g_col
         logic [T_W:0]       diff;
         logic [T_W:0]       offset;
         logic               col_en;
         assign diff   = {1'b0, t_reg} - (T_W+1)'(gi);
         assign col_en = skew_reg ? ((t_reg >= T_W'(gi)) && (diff < (T_W+1)'(rows_reg)))
                                  : ({1'b0, t_reg} < (T_W+1)'(rows_reg));
         assign offset = skew_reg ? diff : {1'b0, t_reg};
         assign rd_en_next[gi] = col_en;
         assign rd_addr_next[gi*ADDR_W +: ADDR_W] = col_en ? (base_addr + ADDR_W'(offset))
                                                           : '0;
      end
   endgenerate

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         t_reg       <= '0;
         m_reg       <= '0;
         n_reg       <= '0;
         rows_reg    <= '0;
         skew_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         rd_en_reg   <= '0;
         rd_addr_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               busy_reg    <= 1'b0;
               done_reg    <= 1'b0;
               rd_en_reg   <= '0;
               rd_addr_reg <= '0;
               if (start) begin
                  if (rows_in_eff != '0) begin
                     m_reg     <= submat_m;
                     n_reg     <= submat_n;
                     rows_reg  <= rows_in_eff;
                     skew_reg  <= skew_mode;
                     t_reg     <= '0;
                     state_reg <= RUN;
                  end else begin
                     state_reg <= FIN;
                  end
               end
            end
            RUN: begin
               busy_reg <= 1'b1;
               done_reg <= 1'b0;
               if (stall) begin
                  // Hold the slot; addresses keep their last value.
                  rd_en_reg <= '0;
               end else begin
                  rd_en_reg   <= rd_en_next;
                  rd_addr_reg <= rd_addr_next;
                  if (last_slot) begin
                     state_reg <= FIN;
                  end else begin
                     t_reg <= t_reg + T_W'(1);
                  end
               end
            end
            FIN: begin
               busy_reg    <= 1'b0;
               done_reg    <= 1'b1;
               rd_en_reg   <= '0;
               rd_addr_reg <= '0;
               t_reg       <= '0;
               state_reg   <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign rd_en       = rd_en_reg;
   assign rd_addr_out = rd_addr_reg;

endmodule

// File: tb/tb_accum_table_rd_seq.sv
// Directed bench for accum_table_rd_seq: table of submatrix reads with
// hand-computed base / slot count / done cycle, plus hand sequences for
// skew snapshots, reset abort and start-with-reset.
module tb_accum_table_rd_seq;

   localparam int COLS   = 16;
   localparam int ADDR_W = 10;
   localparam int AV_W   = ADDR_W * COLS;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [2:0]      submat_m;
   logic [2:0]      submat_n;
   logic [4:0]      num_rows;
   logic            skew_mode;
   logic            stall;
   logic            busy;
   logic            done;
   logic [COLS-1:0] rd_en;
   logic [AV_W-1:0] rd_addr_out;

   accum_table_rd_seq dut (
      .clk(clk), .rst(rst), .start(start), .submat_m(submat_m), .submat_n(submat_n),
      .num_rows(num_rows), .skew_mode(skew_mode), .stall(stall), .busy(busy),
      .done(done), .rd_en(rd_en), .rd_addr_out(rd_addr_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int m; int n; int rows; int reff; bit skew;
      int stall_at; int stall_len;
      int base; int slots; int done_cyc;
   } vec_t;

   vec_t vecs [8];
   int n_cmp  = 0;
   int n_fail = 0;
   logic [COLS-1:0] cap_en   [0:63];
   logic [AV_W-1:0] cap_addr [0:63];

   task automatic check(input string name, input int cyc, input logic [AV_W-1:0] act,
                        input logic [AV_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Expected enables/addresses of one issue slot.
   task automatic slot_model(input int t, input int base, input int r, input bit skew,
                             output logic [COLS-1:0] en, output logic [AV_W-1:0] addr);
      en = '0; addr = '0;
      for (int c = 0; c < COLS; c++) begin
         int d;
         d = skew ? t - c : t;
         if (d >= 0 && d < r) begin
            en[c] = 1'b1;
            addr[c*ADDR_W +: ADDR_W] = ADDR_W'(base + d);
         end
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [COLS-1:0] exp_en;
      logic [AV_W-1:0] exp_addr, prev_addr;
      int cnt [COLS][16];
      int oob, bad, it;
      bit stalled, inj;
      for (int c = 0; c < COLS; c++) for (int r = 0; r < 16; r++) cnt[c][r] = 0;
      oob = 0; it = 0; prev_addr = '0;
      submat_m = 3'(v.m); submat_n = 3'(v.n); num_rows = 5'(v.rows);
      skew_mode = v.skew; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stall = (0 >= v.stall_at) && (0 < v.stall_at + v.stall_len);
      for (int cyc = 1; cyc <= v.done_cyc + 2; cyc++) begin
         @(posedge clk); #1;
         stalled = stall;
         if (cyc < v.done_cyc) begin
            if (stalled) begin
               exp_en = '0; exp_addr = prev_addr;
            end else if (it < v.slots) begin
               slot_model(it, v.base, v.reff, v.skew, exp_en, exp_addr);
               it++;
            end else begin
               exp_en = '0; exp_addr = '0;
            end
            check("busy", cyc, AV_W'(busy), AV_W'(1));
            check("done", cyc, AV_W'(done), AV_W'(0));
         end else begin
            exp_en = '0; exp_addr = '0;
            check("busy", cyc, AV_W'(busy), AV_W'(0));
            check("done", cyc, AV_W'(done), AV_W'(cyc == v.done_cyc));
         end
         check("rd_en", cyc, AV_W'(rd_en), AV_W'(exp_en));
         check("rd_addr", cyc, rd_addr_out, exp_addr);
         prev_addr = exp_addr;
         if (cyc < 64) begin
            cap_en[cyc] = rd_en; cap_addr[cyc] = rd_addr_out;
         end
         for (int c = 0; c < COLS; c++) begin
            if (rd_en[c]) begin
               int a;
               a = int'(rd_addr_out[c*ADDR_W +: ADDR_W]);
               if (a < v.base || a >= v.base + v.reff || a > 1023) oob++;
               else cnt[c][a - v.base]++;
            end
         end
         // Drive inputs for the next edge: stall window and ignored starts.
         stall = (cyc >= v.stall_at) && (cyc < v.stall_at + v.stall_len);
         inj = (v.done_cyc > 3) && ((cyc + 1 == 3) || (cyc + 1 == v.done_cyc));
         start = inj;
         submat_m = inj ? 3'(~v.m) : 3'(v.m);
         num_rows = inj ? 5'd2 : 5'(v.rows);
      end
      start = 1'b0; stall = 1'b0;
      bad = oob;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < v.reff; r++)
            if (cnt[c][r] != 1) bad++;
      check("row_once", idx, AV_W'(bad), AV_W'(0));
      $display("vec %0d m=%0d n=%0d rows=%0d skew=%0d stall=%0d/%0d base=%0d slots=%0d done@%0d",
               idx, v.m, v.n, v.rows, v.skew, v.stall_at, v.stall_len, v.base, v.slots,
               v.done_cyc);
   endtask

   initial begin
      logic [AV_W-1:0] exp_a;
      // m, n, rows, reff, skew, stall_at, stall_len, base, slots, done_cyc
      vecs[0] = '{2, 3, 16, 16, 1'b0, 0,  0, 416,  16, 17};
      vecs[1] = '{0, 0, 16, 16, 1'b1, 0,  0, 0,    31, 32};
      vecs[2] = '{7, 7, 3,  3,  1'b1, 0,  0, 1008, 18, 19};
      vecs[3] = '{1, 0, 8,  8,  1'b0, 4,  3, 16,   8,  12};
      vecs[4] = '{3, 1, 0,  0,  1'b0, 0,  0, 0,    0,  1};
      vecs[5] = '{0, 1, 20, 16, 1'b0, 0,  0, 128,  16, 17};
      vecs[6] = '{5, 2, 1,  1,  1'b1, 0,  0, 336,  16, 17};
      vecs[7] = '{1, 1, 4,  4,  1'b1, 10, 2, 144,  19, 22};

      rst = 1'b1; start = 1'b0; submat_m = '0; submat_n = '0; num_rows = '0;
      skew_mode = 1'b0; stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 0, AV_W'(busy), AV_W'(0));
      check("rst_done", 0, AV_W'(done), AV_W'(0));
      check("rst_en", 0, AV_W'(rd_en), AV_W'(0));
      check("rst_addr", 0, rd_addr_out, AV_W'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_vec(i, vecs[i]);
         if (i == 1) begin
            // Skew snapshots at t=0, t=15, t=30.
            check("skew_t0_en", 1, AV_W'(cap_en[1]), AV_W'(16'h0001));
            check("skew_t0_addr", 1, cap_addr[1], AV_W'(0));
            check("skew_t15_en", 16, AV_W'(cap_en[16]), AV_W'(16'hFFFF));
            exp_a = '0;
            for (int c = 0; c < COLS; c++) exp_a[c*ADDR_W +: ADDR_W] = ADDR_W'(15 - c);
            check("skew_t15_addr", 16, cap_addr[16], exp_a);
            check("skew_t30_en", 31, AV_W'(cap_en[31]), AV_W'(16'h8000));
            exp_a = '0;
            exp_a[15*ADDR_W +: ADDR_W] = 10'd15;
            check("skew_t30_addr", 31, cap_addr[31], exp_a);
         end
      end

      // Reset in the middle of a skewed run: outputs clear, no done pulse.
      submat_m = 3'd0; submat_n = 3'd0; num_rows = 5'd16; skew_mode = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("pre_rst_en", 5, AV_W'(rd_en), AV_W'(16'h001F));
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_en", 6, AV_W'(rd_en), AV_W'(0));
      check("abort_addr", 6, rd_addr_out, AV_W'(0));
      check("abort_busy", 6, AV_W'(busy), AV_W'(0));
      check("abort_done", 6, AV_W'(done), AV_W'(0));
      start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("post_rst_busy", k, AV_W'(busy), AV_W'(0));
         check("post_rst_done", k, AV_W'(done), AV_W'(0));
         check("post_rst_en", k, AV_W'(rd_en), AV_W'(0));
      end
      $display("seq reset-abort and start-with-reset complete");

      // Immediate restart after reset.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      run_vec(8, vecs[2]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
